// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 memory controller: async SRAM sequencing and memory-mapped I/O at IO_ADDR
module lc3_mem_ctrl #(
  parameter int          WRITE_PULSE = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic        Busy,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [2:0] {
    IDLE, RD_ACT, RD_DONE, WR_SETUP, WR_PULSE, WR_RECOV, WR_IO
  } state_t;

  localparam logic [2:0] PULSE_LAST = 3'(WRITE_PULSE - 1);

  state_t      state, state_next;
  logic        oe_d, we_d;
  logic        oe_rise, we_rise, accept, hit_io;
  logic [15:0] sw_meta, sw_sync;
  logic [15:0] mar_q, mdr_q;
  logic        io_q;
  logic [2:0]  pulse_cnt;
  logic        ce, oe, we, dq_en;

  assign oe_rise = Mem_OE & ~oe_d;
  assign we_rise = Mem_WE & ~we_d;
  assign accept  = (state == IDLE) && (oe_rise || we_rise);
  assign hit_io  = (MAR == IO_ADDR);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Edge flags track the strobes every cycle, so an edge seen while busy is lost for good.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      oe_d        <= 1'b0;
      we_d        <= 1'b0;
      sw_meta     <= '0;
      sw_sync     <= '0;
      mar_q       <= '0;
      mdr_q       <= '0;
      io_q        <= 1'b0;
      pulse_cnt   <= '0;
      Data_to_CPU <= '0;
      HEX_Data    <= '0;
    end else begin
      oe_d    <= Mem_OE;
      we_d    <= Mem_WE;
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      if (accept) begin
        mar_q <= MAR;
        mdr_q <= MDR;
        io_q  <= hit_io;
      end
      if (state == RD_ACT) Data_to_CPU <= io_q ? sw_sync : SRAM_DQ_in;
      if (state == WR_IO)  HEX_Data    <= mdr_q;
      if (state == WR_SETUP)      pulse_cnt <= PULSE_LAST;
      else if (state == WR_PULSE) pulse_cnt <= pulse_cnt - 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    Data_valid = 1'b0;
    ce         = 1'b0;
    oe         = 1'b0;
    we         = 1'b0;
    dq_en      = 1'b0;
    case (state)
      IDLE: begin
        // A write edge beats a simultaneous read edge.
        if (we_rise)      state_next = hit_io ? WR_IO : WR_SETUP;
        else if (oe_rise) state_next = RD_ACT;
      end
      RD_ACT: begin
        ce         = ~io_q;
        oe         = ~io_q;
        state_next = RD_DONE;
      end
      RD_DONE: begin
        Data_valid = 1'b1;
        state_next = IDLE;
      end
      WR_SETUP: begin
        ce         = 1'b1;
        dq_en      = 1'b1;
        state_next = WR_PULSE;
      end
      WR_PULSE: begin
        ce    = 1'b1;
        dq_en = 1'b1;
        we    = 1'b1;
        if (pulse_cnt == 3'd0) state_next = WR_RECOV;
      end
      WR_RECOV: begin
        ce         = 1'b1;
        dq_en      = 1'b1;
        state_next = IDLE;
      end
      WR_IO:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy        = (state != IDLE);
  assign SRAM_ADDR   = {4'b0000, mar_q};
  assign SRAM_DQ_out = mdr_q;
  assign SRAM_DQ_oe  = dq_en;
  assign SRAM_CE_N   = ~ce;
  assign SRAM_OE_N   = ~oe;
  assign SRAM_WE_N   = ~we;
  assign SRAM_UB_N   = ~ce;
  assign SRAM_LB_N   = ~ce;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - randomized bench for lc3_mem_ctrl against a transaction-level memory model
module tb_lc3_mem_ctrl;

  localparam int WP = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] MAR = '0;
  logic [15:0] MDR = '0;
  logic [15:0] Switches = '0;
  logic [15:0] Data_to_CPU;
  logic        Data_valid;
  logic        Busy;
  logic [15:0] HEX_Data;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  lc3_mem_ctrl #(.WRITE_PULSE(WP), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Switches(Switches),
    .Data_to_CPU(Data_to_CPU), .Data_valid(Data_valid), .Busy(Busy), .HEX_Data(HEX_Data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a == 16'h3000) ? 16'hABCD : (a ^ 16'h5A5A);
  endfunction

  // External SRAM: unwritten words hold init_word(addr)
  logic [15:0] sram [65536];
  bit          sram_written [65536];
  logic [15:0] sram_a;
  assign sram_a     = SRAM_ADDR[15:0];
  assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ?
                      (sram_written[sram_a] ? sram[sram_a] : init_word(sram_a)) : 16'hDEAD;

  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) begin
      sram[sram_a]         <= SRAM_DQ_out;
      sram_written[sram_a] <= 1'b1;
    end
  end

  function automatic logic [15:0] sram_word(input logic [15:0] a);
    return sram_written[a] ? sram[a] : init_word(a);
  endfunction

  // Reference: expected memory contents and I/O registers
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] last_rd = '0;
  logic [15:0] sw_exp = '0;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input int hold);
    int busy_n, valid_n, oe_low_n, we_low_n, ce_low_n, dq_oe_n, dq_bad;
    int first_we, oe_idx, valid_idx;
    logic [15:0] got;
    bit is_io;
    busy_n = 0; valid_n = 0; oe_low_n = 0; we_low_n = 0; ce_low_n = 0;
    dq_oe_n = 0; dq_bad = 0; first_we = -1; oe_idx = -1; valid_idx = -1; got = '0;
    is_io = (addr == 16'hFFFF);
    @(posedge Clk); #1;
    Mem_OE = rd; Mem_WE = wr; MAR = addr; MDR = data;
    for (int c = 0; c < 14; c++) begin
      if (c == hold) begin Mem_OE = 1'b0; Mem_WE = 1'b0; end
      if (c == 1) begin MAR = 16'($urandom); MDR = 16'($urandom); end
      @(negedge Clk);
      if (c == 0) check("data_hold", Data_to_CPU, last_rd);
      if (Busy) busy_n++;
      if (!SRAM_CE_N) ce_low_n++;
      if (!SRAM_OE_N) begin oe_low_n++; oe_idx = c; end
      if (!SRAM_WE_N) begin we_low_n++; if (first_we < 0) first_we = c; end
      if (SRAM_DQ_oe) begin dq_oe_n++; if (SRAM_DQ_out !== data) dq_bad++; end
      if (Data_valid) begin valid_n++; valid_idx = c; got = Data_to_CPU; end
      @(posedge Clk); #1;
    end
    if (wr) begin
      check("wr_valid_n", valid_n, 0);
      check("wr_oe_low", oe_low_n, 0);
      if (is_io) begin
        check("io_wr_busy", busy_n, 1);
        check("io_wr_strobes", ce_low_n + we_low_n + dq_oe_n, 0);
        check("io_wr_hex", HEX_Data, data);
      end else begin
        check("wr_busy", busy_n, WP + 2);
        check("wr_we_low", we_low_n, WP);
        check("wr_first_we", first_we, 2);
        check("wr_dq_oe_n", dq_oe_n, WP + 2);
        check("wr_dq_data", dq_bad, 0);
        ref_mem[addr] = data;
        check("wr_sram", sram_word(addr), ref_rd(addr));
      end
    end else begin
      check("rd_busy", busy_n, 2);
      check("rd_valid_n", valid_n, 1);
      check("rd_valid_idx", valid_idx, 2);
      check("rd_we_low", we_low_n, 0);
      if (is_io) begin
        check("io_rd_ce_low", ce_low_n + oe_low_n, 0);
        check("io_rd_data", got, sw_exp);
        last_rd = sw_exp;
      end else begin
        check("rd_oe_low", oe_low_n, 1);
        check("rd_oe_idx", oe_idx, 1);
        check("rd_data", got, ref_rd(addr));
        last_rd = ref_rd(addr);
      end
    end
  endtask

  task automatic set_switches(input logic [15:0] v);
    Switches = v;
    sw_exp = v;
    repeat (3) @(posedge Clk);
  endtask

  initial begin
    int op, asel, hold;
    logic [15:0] a;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_data", Data_to_CPU, 16'h0000);
    check("rst_valid", Data_valid, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_hex", HEX_Data, 16'h0000);
    check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("rst_dq_oe", SRAM_DQ_oe, 1'b0);
    check("rst_addr", SRAM_ADDR, 20'h0);

    access(1'b1, 1'b0, 16'h3000, 16'h0000, 3);
    access(1'b0, 1'b1, 16'h0040, 16'h1234, 3);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 3);
    set_switches(16'h00FF);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3);
    access(1'b0, 1'b1, 16'hFFFF, 16'hBEEF, 3);
    access(1'b1, 1'b1, 16'h0010, 16'h5555, 3);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 10);
    access(1'b0, 1'b1, 16'hFFFE, 16'hA5A5, 3);
    access(1'b0, 1'b1, 16'h0000, 16'h0F0F, 3);
    access(1'b1, 1'b0, 16'hFFFE, 16'h0000, 3);
    access(1'b1, 1'b0, 16'h0000, 16'h0000, 3);

    for (int i = 0; i < 60; i++) begin
      op   = int'($urandom_range(0, 5));
      asel = int'($urandom_range(0, 9));
      a = (asel == 0) ? 16'hFFFF : (asel == 1) ? 16'hFFFE : (asel == 2) ? 16'h0000 :
          16'($urandom_range(0, 31));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 10)) : 3;
      if (op <= 2 && a == 16'hFFFF) set_switches(16'($urandom));
      access((op <= 2) || (op == 5), op >= 3, a, 16'($urandom), hold);
    end

    access(1'b0, 1'b1, 16'hFFFF, 16'hBEEF, 3);
    @(posedge Clk); #1;
    Mem_WE = 1'b1; MAR = 16'h7777; MDR = 16'h4242;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("pre_rst_we", SRAM_WE_N, 1'b0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("abort_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("abort_dq_oe", SRAM_DQ_oe, 1'b0);
    check("abort_busy", Busy, 1'b0);
    check("abort_hex", HEX_Data, 16'h0000);
    check("abort_data", Data_to_CPU, 16'h0000);
    Reset = 1'b0;
    Mem_WE = 1'b0;
    repeat (2) @(posedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
